// File: rtl/instrumented_adder_core.sv
// Instrumented 32-bit adder: operands and masks loaded over LA strobes, with an
// optional ring-oscillator loop through a selected A bit and a toggle counter.
module instrumented_adder_core #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IO_W     = 38,
    parameter int unsigned RING_PIN = 8,
    parameter int unsigned EXT_PIN  = 9
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             active,
    input  logic [WIDTH-1:0] la1_data_in,
    input  logic [WIDTH-1:0] la1_oenb,
    input  logic [WIDTH-1:0] la2_data_in,
    input  logic [WIDTH-1:0] la2_oenb,
    input  logic [WIDTH-1:0] la3_data_in,
    input  logic [WIDTH-1:0] la3_oenb,
    input  logic [IO_W-1:0]  io_in,
    output logic [WIDTH-1:0] la1_data_out,
    output logic [WIDTH-1:0] la2_data_out,
    output logic [WIDTH-1:0] la3_data_out,
    output logic [IO_W-1:0]  io_out,
    output logic [IO_W-1:0]  io_oeb
);

    localparam int unsigned NUM_STROBES = 7;

    logic [WIDTH-1:0]       a_input;
    logic [WIDTH-1:0]       b_input;
    logic [WIDTH-1:0]       a_input_ext_bit_b;
    logic [WIDTH-1:0]       a_input_ring_bit_b;
    logic [WIDTH-1:0]       s_output_bit_b;
    logic                   run;
    logic                   chain_out;
    logic                   chain_out_d;
    logic [WIDTH-1:0]       count;

    logic [NUM_STROBES-1:0] strobe;
    logic [WIDTH-1:0]       wr_data;
    logic [WIDTH-1:0]       a_eff;
    logic [WIDTH:0]         sum_full;
    logic [WIDTH-1:0]       sum;
    logic                   carry_out;
    logic                   feedback;
    logic                   ring_rise;
    logic                   unused_inputs;

    // Qualified command strobes and masked write data.
    assign strobe  = {NUM_STROBES{active}} & la1_data_in[NUM_STROBES-1:0]
                     & ~la1_oenb[NUM_STROBES-1:0];
    assign wr_data = la2_data_in & ~la2_oenb;

    // Per-bit A source: ring node beats external pin beats stored operand.
    assign a_eff = (a_input_ring_bit_b & {WIDTH{chain_out}})
                 | (~a_input_ring_bit_b & a_input_ext_bit_b & {WIDTH{io_in[EXT_PIN]}})
                 | (~a_input_ring_bit_b & ~a_input_ext_bit_b & a_input);

    // Adder and inverted-feedback tap.
    assign sum_full  = {1'b0, a_eff} + {1'b0, b_input};
    assign sum       = sum_full[WIDTH-1:0];
    assign carry_out = sum_full[WIDTH];
    assign feedback  = |(sum & s_output_bit_b);
    assign ring_rise = active & run & chain_out & ~chain_out_d;

    assign unused_inputs = &{1'b0, la1_data_in[WIDTH-1:NUM_STROBES],
                             la1_oenb[WIDTH-1:NUM_STROBES], la3_data_in, la3_oenb, io_in};

    // Register file, ring node and toggle counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            a_input            <= '0;
            b_input            <= '0;
            a_input_ext_bit_b  <= '0;
            a_input_ring_bit_b <= '0;
            s_output_bit_b     <= '0;
            run                <= 1'b0;
            chain_out          <= 1'b0;
            chain_out_d        <= 1'b0;
            count              <= '0;
        end else begin
            if (strobe[0]) a_input            <= wr_data;
            if (strobe[1]) b_input            <= wr_data;
            if (strobe[2]) a_input_ext_bit_b  <= wr_data;
            if (strobe[3]) a_input_ring_bit_b <= wr_data;
            if (strobe[4]) s_output_bit_b     <= wr_data;
            if (strobe[5]) run                <= wr_data[0];

            chain_out <= (run & active) ? ~feedback : 1'b0;
            if (active) chain_out_d <= chain_out;

            // Clear wins over a simultaneous increment.
            if (strobe[6])      count <= '0;
            else if (ring_rise) count <= count + WIDTH'(1);
        end
    end

    // Output parking when the slot is inactive.
    always_comb begin
        la1_data_out = '0;
        la2_data_out = '0;
        la3_data_out = '0;
        io_out       = '0;
        io_oeb       = '1;
        if (active) begin
            la1_data_out         = sum;
            la2_data_out         = {{(WIDTH-2){1'b0}}, chain_out, carry_out};
            la3_data_out         = count;
            io_out[RING_PIN]     = chain_out;
            io_out[RING_PIN+1]   = carry_out;
            io_oeb[RING_PIN]     = 1'b0;
            io_oeb[RING_PIN+1]   = 1'b0;
        end
    end

endmodule

// File: tb/tb_instrumented_adder_core.sv
// Directed bench for instrumented_adder_core.
module tb_instrumented_adder_core;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        active;
    logic [31:0] la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb;
    logic [37:0] io_in;
    logic [31:0] la1_data_out, la2_data_out, la3_data_out;
    logic [37:0] io_out, io_oeb;

    int passed = 0;
    int total  = 0;

    instrumented_adder_core dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .active      (active),
        .la1_data_in (la1_data_in),
        .la1_oenb    (la1_oenb),
        .la2_data_in (la2_data_in),
        .la2_oenb    (la2_oenb),
        .la3_data_in (la3_data_in),
        .la3_oenb    (la3_oenb),
        .io_in       (io_in),
        .la1_data_out(la1_data_out),
        .la2_data_out(la2_data_out),
        .la3_data_out(la3_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] strobes, input logic [31:0] data);
        la1_data_in = strobes;
        la2_data_in = data;
        tick();
        la1_data_in = '0;
        la2_data_in = '0;
    endtask

    initial begin
        wb_rst_i = 1'b1; active = 1'b0;
        la1_data_in = '0; la1_oenb = '0; la2_data_in = '0; la2_oenb = '0;
        la3_data_in = '0; la3_oenb = '0; io_in = '0;

        // reset, slot inactive then active
        tick(); tick();
        check("rst_la1", 64'(la1_data_out), 64'h0);
        check("rst_la3", 64'(la3_data_out), 64'h0);
        check("rst_oeb_inactive", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        check("rst_io_out", 64'(io_out), 64'h0);
        active = 1'b1;
        tick();
        check("rst_oeb_active", 64'(io_oeb), 64'h3F_FFFF_FCFF);
        check("rst_la2", 64'(la2_data_out), 64'h0);
        wb_rst_i = 1'b0;

        // basic add with carry
        wr(32'h1, 32'h0000_0005);
        wr(32'h2, 32'hFFFF_FFFE);
        check("add_sum", 64'(la1_data_out), 64'h3);
        check("add_la2", 64'(la2_data_out), 64'h1);
        check("add_io_out", 64'(io_out), 64'h200);

        // disabled strobe, then masked data
        la1_oenb = 32'h1;
        wr(32'h1, 32'h0000_0077);
        la1_oenb = '0;
        check("oenb_strobe_ignored", 64'(la1_data_out), 64'h3);
        la2_oenb = 32'hFFFF_0000;
        wr(32'h1, 32'h1234_5678);
        la2_oenb = '0;
        check("masked_data_sum", 64'(la1_data_out), 64'h5676);
        check("masked_data_carry", 64'(la2_data_out), 64'h1);

        // two strobes share one data word
        wr(32'h3, 32'h8000_0000);
        check("dual_strobe_sum", 64'(la1_data_out), 64'h0);
        check("dual_strobe_carry", 64'(la2_data_out), 64'h1);

        // external A-bit source, then ring priority
        wr(32'h3, 32'h0);
        wr(32'h2, 32'h1);
        wr(32'h4, 32'h1);
        io_in[9] = 1'b1; #1;
        check("ext_bit_one", 64'(la1_data_out), 64'h2);
        io_in[9] = 1'b0; #1;
        check("ext_bit_zero", 64'(la1_data_out), 64'h1);
        io_in[9] = 1'b1;
        wr(32'h8, 32'h1);
        check("ring_over_ext", 64'(la1_data_out), 64'h1);
        wr(32'hE, 32'h0);
        io_in = '0;

        // ring oscillator on bit 14
        wr(32'h18, 32'h0000_4000);
        wr(32'h20, 32'h1);
        check("ring_start_la2", 64'(la2_data_out), 64'h0);
        check("ring_start_cnt", 64'(la3_data_out), 64'h0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            check($sformatf("ring_chain_%0d", n), 64'(la2_data_out), 64'((n % 2) * 2));
            check($sformatf("ring_count_%0d", n), 64'(la3_data_out), 64'(n / 2));
        end
        tick();
        check("ring_sum_high", 64'(la1_data_out), 64'h4000);
        check("ring_count_pre_clr", 64'(la3_data_out), 64'd10);
        wr(32'h40, 32'h0);
        check("clear_beats_inc", 64'(la3_data_out), 64'h0);
        tick(); tick();
        check("count_after_clear", 64'(la3_data_out), 64'h1);
        tick();

        // drop active while the ring runs
        active = 1'b0; #1;
        check("inactive_la1", 64'(la1_data_out), 64'h0);
        check("inactive_la2", 64'(la2_data_out), 64'h0);
        check("inactive_la3", 64'(la3_data_out), 64'h0);
        check("inactive_io_out", 64'(io_out), 64'h0);
        check("inactive_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        tick(); tick();
        check("inactive_hold_la3", 64'(la3_data_out), 64'h0);
        active = 1'b1; #1;
        check("reactivate_count_frozen", 64'(la3_data_out), 64'h1);
        check("reactivate_chain_low", 64'(la2_data_out), 64'h0);
        tick();
        check("resume_chain_high", 64'(la2_data_out), 64'h2);
        check("resume_count", 64'(la3_data_out), 64'h1);

        // reset mid-run
        wb_rst_i = 1'b1;
        tick();
        check("midrst_la1", 64'(la1_data_out), 64'h0);
        check("midrst_la2", 64'(la2_data_out), 64'h0);
        check("midrst_la3", 64'(la3_data_out), 64'h0);
        check("midrst_io_out", 64'(io_out), 64'h0);
        wb_rst_i = 1'b0;
        tick(); tick();
        check("postrst_no_osc", 64'(la2_data_out), 64'h0);
        check("postrst_count", 64'(la3_data_out), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
